// File: rtl/dram_write_ctrl.sv
// Write-side DRAM responder: command and data FIFOs feeding single-outstanding AXI4 INCR write bursts.
// Optional DRAM_WRITE_CTRL_STATS_EN adds burst_count/word_count outputs.

module dram_write_ctrl_fifo #(
  parameter int WIDTH      = 36,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg, rd_addr_next;
  logic [DEPTH_LOG2:0]   count_reg;
  logic [WIDTH-1:0]      head_reg;
  logic                  push_ok, pop_ok;

  assign full     = count_reg[DEPTH_LOG2];
  assign empty    = (count_reg == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign overflow = push & full;
  assign count    = count_reg;
  assign dout     = head_reg;

  assign rd_addr_next = pop_ok ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

  // Registered read of the next head; bypass when that slot is being written this cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      head_reg <= '0;
    end else if (push_ok && (wr_ptr_reg == rd_addr_next)) begin
      head_reg <= din;
    end else begin
      head_reg <= mem[rd_addr_next];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      rd_ptr_reg <= rd_addr_next;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

module dram_write_ctrl #(
  parameter int CTRL_DEPTH_LOG2 = 4,
  parameter int DATA_DEPTH_LOG2 = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [39:0] ctrl_in,
  input  logic        ctrl_we,
  input  logic [35:0] data_in,
  input  logic        data_we,
  output logic        ctrl_full,
  output logic        data_full,
  output logic [31:0] m_awaddr,
  output logic [7:0]  m_awlen,
  output logic [2:0]  m_awsize,
  output logic [1:0]  m_awburst,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wlast,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic        busy,
  output logic        err
`ifdef DRAM_WRITE_CTRL_STATS_EN
  ,
  output logic [31:0] burst_count,
  output logic [31:0] word_count
`endif
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t state_reg, state_next;
  logic [31:0] awaddr_reg, awaddr_next;
  logic [7:0]  awlen_reg, awlen_next;
  logic [8:0]  beat_reg, beat_next;
  logic        err_reg, err_next;

  logic [39:0]              cmd_head;
  logic [CTRL_DEPTH_LOG2:0] cmd_count;
  logic                     cmd_empty, cmd_overflow, cmd_pop;
  logic [35:0]              data_head;
  logic [DATA_DEPTH_LOG2:0] data_count;
  logic                     data_empty, data_overflow, data_pop;
  logic [8:0]               head_beats;
  logic                     burst_ready;

  dram_write_ctrl_fifo #(.WIDTH(40), .DEPTH_LOG2(CTRL_DEPTH_LOG2)) u_cmd_fifo (
    .CLK(CLK), .RST(RST), .push(ctrl_we), .din(ctrl_in), .pop(cmd_pop), .dout(cmd_head),
    .count(cmd_count), .full(ctrl_full), .empty(cmd_empty), .overflow(cmd_overflow)
  );

  dram_write_ctrl_fifo #(.WIDTH(36), .DEPTH_LOG2(DATA_DEPTH_LOG2)) u_data_fifo (
    .CLK(CLK), .RST(RST), .push(data_we), .din(data_in), .pop(data_pop), .dout(data_head),
    .count(data_count), .full(data_full), .empty(data_empty), .overflow(data_overflow)
  );

  // A burst is launched only once all of its words are buffered, so W never bubbles.
  assign head_beats  = (cmd_head[39:32] == 8'd0) ? 9'd256 : {1'b0, cmd_head[39:32]};
  assign burst_ready = ~cmd_empty && (32'(data_count) >= 32'(head_beats));

  assign m_awaddr  = awaddr_reg;
  assign m_awlen   = awlen_reg;
  assign m_awsize  = 3'b010;
  assign m_awburst = 2'b01;
  assign m_wdata   = data_head[31:0];
  assign m_wstrb   = data_head[35:32];
  assign err       = err_reg;
  assign busy      = (state_reg != IDLE) | ~cmd_empty | ~data_empty;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= IDLE;
      awaddr_reg <= '0;
      awlen_reg  <= '0;
      beat_reg   <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      awaddr_reg <= awaddr_next;
      awlen_reg  <= awlen_next;
      beat_reg   <= beat_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    awaddr_next = awaddr_reg;
    awlen_next  = awlen_reg;
    beat_next   = beat_reg;
    err_next    = err_reg | cmd_overflow | data_overflow;
    cmd_pop     = 1'b0;
    data_pop    = 1'b0;
    m_awvalid   = 1'b0;
    m_wvalid    = 1'b0;
    m_wlast     = 1'b0;
    m_bready    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (burst_ready) begin
          cmd_pop     = 1'b1;
          awaddr_next = {cmd_head[31:2], 2'b00};
          awlen_next  = cmd_head[39:32] - 8'd1;
          beat_next   = head_beats;
          state_next  = ADDR;
        end
      end
      ADDR: begin
        m_awvalid = 1'b1;
        if (m_awready) state_next = DATA;
      end
      DATA: begin
        m_wvalid = 1'b1;
        m_wlast  = (beat_reg == 9'd1);
        if (m_wready) begin
          data_pop  = 1'b1;
          beat_next = beat_reg - 9'd1;
          if (beat_reg == 9'd1) state_next = RESP;
        end
      end
      RESP: begin
        m_bready = 1'b1;
        if (m_bvalid) begin
          if (m_bresp != 2'b00) err_next = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef DRAM_WRITE_CTRL_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      burst_count <= '0;
      word_count  <= '0;
    end else begin
      if (m_bvalid & m_bready) burst_count <= burst_count + 32'd1;
      if (m_wvalid & m_wready) word_count  <= word_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dram_write_ctrl.sv
// Randomized directed bench for dram_write_ctrl with a queue-based reference of expected AW/W traffic.
`timescale 1ns/1ps
module tb_dram_write_ctrl;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [39:0] ctrl_in = '0;
  logic        ctrl_we = 1'b0;
  logic [35:0] data_in = '0;
  logic        data_we = 1'b0;
  logic        ctrl_full, data_full;
  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic        m_awvalid;
  logic        m_awready = 1'b0;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast, m_wvalid;
  logic        m_wready = 1'b0;
  logic [1:0]  m_bresp = 2'b00;
  logic        m_bvalid = 1'b0;
  logic        m_bready, busy, err;
`ifdef DRAM_WRITE_CTRL_STATS_EN
  logic [31:0] burst_count, word_count;
`endif

  dram_write_ctrl dut (
    .CLK(CLK), .RST(RST), .ctrl_in(ctrl_in), .ctrl_we(ctrl_we), .data_in(data_in), .data_we(data_we),
    .ctrl_full(ctrl_full), .data_full(data_full), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready), .busy(busy), .err(err)
`ifdef DRAM_WRITE_CTRL_STATS_EN
    , .burst_count(burst_count), .word_count(word_count)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    int          beats;
  } aw_t;

  int tests = 0;
  int fails = 0;
  aw_t aw_q[$];
  logic [35:0] data_q[$];
  int w_rem = 0, pending_b = 0, aw_hs = 0, w_hs = 0, b_hs = 0, cmd_occ = 0;
  int wc_since_rst = 0, bc_since_rst = 0;
  logic exp_err = 1'b0;
  int pct_aw = 100, pct_w = 100, pct_b = 100;
  logic [1:0] bresp_val = 2'b00;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic roll(input int pct);
    return ($urandom_range(99) < 32'(pct));
  endfunction

  // Observe the AXI side in mid-cycle and compare against the expected transaction queues.
  task automatic monitor();
    if (w_rem > 0) chk("wvalid_gap", 64'(m_wvalid), 64'd1);
    if (m_wvalid) begin
      if (w_rem == 0 || data_q.size() == 0) begin
        chk("w_unexpected", 64'(m_wvalid), 64'd0);
      end else begin
        chk("wdata", 64'(m_wdata), 64'(data_q[0][31:0]));
        chk("wstrb", 64'(m_wstrb), 64'(data_q[0][35:32]));
        chk("wlast", 64'(m_wlast), 64'(w_rem == 1));
        if (m_wready) begin
          void'(data_q.pop_front());
          w_rem--;
          w_hs++;
          wc_since_rst++;
          if (w_rem == 0) pending_b++;
        end
      end
    end
    if (m_bready) begin
      chk("bready_early", 64'(m_bready), 64'(pending_b > 0));
      if (m_bvalid && pending_b > 0) begin
        pending_b--;
        b_hs++;
        bc_since_rst++;
        if (bresp_val != 2'b00) exp_err = 1'b1;
      end
    end
    if (m_awvalid) begin
      if (aw_q.size() == 0) begin
        chk("aw_unexpected", 64'(m_awvalid), 64'd0);
      end else begin
        chk("awaddr", 64'(m_awaddr), 64'(aw_q[0].addr));
        chk("awlen", 64'(m_awlen), 64'(aw_q[0].len));
        if (m_awready) begin
          chk("aw_outstanding", 64'(w_rem + pending_b), 64'd0);
          w_rem = aw_q[0].beats;
          void'(aw_q.pop_front());
          aw_hs++;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    if (!RST) monitor();
    @(posedge CLK);
    #1;
    ctrl_we   = 1'b0;
    data_we   = 1'b0;
    m_awready = roll(pct_aw);
    m_wready  = roll(pct_w);
    m_bvalid  = (pending_b > 0) && roll(pct_b);
    m_bresp   = bresp_val;
  endtask

  task automatic push_cmd(input logic [7:0] len, input logic [31:0] addr);
    aw_t a;
    ctrl_in = {len, addr};
    ctrl_we = 1'b1;
    if (cmd_occ >= 16) begin
      exp_err = 1'b1;
    end else begin
      a.addr  = {addr[31:2], 2'b00};
      a.len   = len - 8'd1;
      a.beats = (len == 8'd0) ? 256 : int'(len);
      aw_q.push_back(a);
      cmd_occ++;
    end
    tick();
  endtask

  task automatic push_data(input logic [35:0] w);
    data_in = w;
    data_we = 1'b1;
    data_q.push_back(w);
    tick();
  endtask

  task automatic push_burst(input logic [7:0] len, input logic [31:0] addr);
    int beats;
    logic [35:0] w;
    beats = (len == 8'd0) ? 256 : int'(len);
    push_cmd(len, addr);
    for (int i = 0; i < beats; i++) begin
      w = {4'($urandom_range(15)), 32'($urandom())};
      push_data(w);
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((aw_q.size() > 0 || data_q.size() > 0 || w_rem > 0 || pending_b > 0) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 64'(n < budget), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'(exp_err));
    cmd_occ = 0;
  endtask

  initial begin
    int n;
    int base;

    // Reset state
    RST = 1'b1;
    repeat (3) tick();
    chk("rst_awvalid", 64'(m_awvalid), 64'd0);
    chk("rst_wvalid", 64'(m_wvalid), 64'd0);
    chk("rst_wlast", 64'(m_wlast), 64'd0);
    chk("rst_bready", 64'(m_bready), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_awaddr", 64'(m_awaddr), 64'd0);
    chk("rst_awlen", 64'(m_awlen), 64'd0);
    chk("rst_wdata", 64'(m_wdata), 64'd0);
    chk("rst_wstrb", 64'(m_wstrb), 64'd0);
    chk("rst_ctrl_full", 64'(ctrl_full), 64'd0);
    chk("rst_data_full", 64'(data_full), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("awsize", 64'(m_awsize), 64'd2);
    chk("awburst", 64'(m_awburst), 64'd1);
    RST = 1'b0;
    tick();

    // Single burst of counting data
    push_cmd(8'd64, 32'h0100_0000);
    for (int i = 0; i < 64; i++) push_data({4'hF, 32'(i)});
    drain("single", 500);
    $display("[TB] single burst done: aw=%0d w=%0d b=%0d", aw_hs, w_hs, b_hs);

    // Command waits until its data is fully buffered
    push_cmd(8'd16, 32'h0200_0040);
    for (int i = 0; i < 15; i++) push_data({4'h5, 32'($urandom())});
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("lag_awvalid_low", 64'(m_awvalid), 64'd0);
    end
    push_data({4'hA, 32'($urandom())});
    chk("lag_awvalid_pre", 64'(m_awvalid), 64'd0);
    tick();
    chk("lag_awvalid_rise", 64'(m_awvalid), 64'd1);
    drain("lag", 500);
    $display("[TB] data lag done: aw=%0d w=%0d b=%0d", aw_hs, w_hs, b_hs);

    // Random backpressure on three back-to-back bursts
    pct_aw = 30; pct_w = 30; pct_b = 30;
    base = w_hs;
    for (int k = 0; k < 3; k++) push_burst(8'd64, {$urandom()} & 32'hFFFF_FFF0);
    drain("bp", 5000);
    chk("bp_beats", 64'(w_hs - base), 64'd192);
    $display("[TB] backpressure done: aw=%0d w=%0d b=%0d", aw_hs, w_hs, b_hs);

    // Length 0 means 256 beats; SLVERR makes err sticky
    pct_aw = 100; pct_w = 100; pct_b = 100;
    bresp_val = 2'b10;
    push_burst(8'd0, 32'h0000_1003);
    drain("len0", 2000);
    bresp_val = 2'b00;
    $display("[TB] len0/slverr done: err=%0b", err);

    // Command FIFO overflow
    pct_aw = 0; pct_w = 0; pct_b = 0;
    base = aw_hs;
    for (int i = 0; i < 17; i++) begin
      push_cmd(8'd4, 32'h2000_0000 + 32'(i * 16));
      if (i == 14) chk("ovf_not_full", 64'(ctrl_full), 64'd0);
      if (i == 15) chk("ovf_full", 64'(ctrl_full), 64'd1);
    end
    chk("ovf_full_after", 64'(ctrl_full), 64'd1);
    chk("ovf_err", 64'(err), 64'd1);
    for (int i = 0; i < 64; i++) push_data({4'h3, 32'($urandom())});
    pct_aw = 100; pct_w = 100; pct_b = 100;
    drain("ovf", 3000);
    chk("ovf_aw_count", 64'(aw_hs - base), 64'd16);
    $display("[TB] overflow done: aw_handshakes=%0d", aw_hs - base);

    // Reset in the middle of a burst
    push_burst(8'd64, 32'h3000_0000);
    base = w_hs;
    n = 0;
    while ((w_hs - base) < 10 && n < 300) begin
      tick();
      n++;
    end
    chk("mid_reached", 64'(n < 300), 64'd1);
    RST = 1'b1;
    tick();
    chk("mid_wvalid", 64'(m_wvalid), 64'd0);
    chk("mid_awvalid", 64'(m_awvalid), 64'd0);
    chk("mid_bready", 64'(m_bready), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_err", 64'(err), 64'd0);
    chk("mid_ctrl_full", 64'(ctrl_full), 64'd0);
    chk("mid_data_full", 64'(data_full), 64'd0);
    RST = 1'b0;
    aw_q.delete();
    data_q.delete();
    w_rem = 0; pending_b = 0; cmd_occ = 0; exp_err = 1'b0;
    wc_since_rst = 0; bc_since_rst = 0;
    tick();
    push_burst(8'd4, 32'h4000_0010);
    drain("post_rst", 200);
    $display("[TB] reset mid-burst done: aw=%0d w=%0d b=%0d", aw_hs, w_hs, b_hs);
`ifdef DRAM_WRITE_CTRL_STATS_EN
    chk("word_count", 64'(word_count), 64'(wc_since_rst));
    chk("burst_count", 64'(burst_count), 64'(bc_since_rst));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dram_write_ctrl.md
Name: dram_write_ctrl

Overview:
- Write-side responder for the image-processing DRAM path: accepts burst commands on ctrl_in/ctrl_we and write beats on data_in/data_we, then issues them as AXI4 INCR write bursts to the DRAM controller.
- Sits between the processing pipeline's write interface and the MIG/AXI interconnect.
- Decouples producer timing through internal command and data FIFOs.
- Keeps at most one burst outstanding.

Parameters:
- CTRL_DEPTH_LOG2, 4, command FIFO depth = 2^4 entries of 40 bits.
- DATA_DEPTH_LOG2, 10, data FIFO depth = 1024 entries of 36 bits.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high; clock CLK.
- ctrl_in  in  40  [39:32] burst length in words (0 means 256), [31:0] byte address.
- ctrl_we  in  1  push ctrl_in into the command FIFO.
- data_in  in  36  [35:32] byte strobe, [31:0] data.
- data_we  in  1  push data_in into the data FIFO.
- ctrl_full  out  1  command FIFO full.
- data_full  out  1  data FIFO full.
- m_awaddr  out  32  AXI write address.
- m_awlen  out  8  AXI beats minus 1.
- m_awsize  out  3  constant 3'b010.
- m_awburst  out  2  constant 2'b01.
- m_awvalid  out  1.
- m_awready  in  1.
- m_wdata  out  32.
- m_wstrb  out  4.
- m_wlast  out  1.
- m_wvalid  out  1.
- m_wready  in  1.
- m_bresp  in  2.
- m_bvalid  in  1.
- m_bready  out  1.
- busy  out  1  burst in progress, or either FIFO non-empty.
- err  out  1  sticky: SLVERR/DECERR response, or push while full.

Behaviour:
- Reset: all FIFOs emptied; state IDLE.
  - awvalid, wvalid, wlast, bready, err = 0; awaddr, awlen, wdata, wstrb = 0.
  - ctrl_full = data_full = busy = 0.
  - RST mid-burst aborts immediately; no drain or completion of the AXI transaction.
- FIFOs: first-word-fall-through.
  - A push while full is dropped, FIFO contents are unchanged, and err is set.
  - Simultaneous push and pop on a full FIFO is treated as full (push dropped).
  - Data words are consumed strictly in order; the command len defines how many words belong to each burst.
- Length rule: beats = (len==0) ? 256 : len; m_awlen = len - 1 (mod 256). Address bits [1:0] are forced to 0 on m_awaddr.
- States:
  - IDLE:
    - Condition: command FIFO non-empty and data FIFO count >= beats of the head command.
    - Action: pop the command, register awaddr/awlen, load beat counter = beats, go to ADDR.
    - The pop-to-awvalid latency is exactly 1 cycle.
    - Requiring the full burst to be buffered guarantees wvalid never deasserts within a burst.
  - ADDR:
    - awvalid = 1, held with awaddr/awlen stable until awready.
    - On the awready cycle go to DATA; wvalid is first asserted the next cycle.
  - DATA:
    - wvalid = 1; wdata/wstrb come from the data FIFO head.
    - On each wvalid & wready: pop data, decrement beat counter.
    - wlast = 1 when counter == 1. The handshake of the last beat goes to RESP.
    - wready low stalls; outputs hold.
  - RESP:
    - bready = 1. On bvalid: if bresp != 2'b00 set err; return to IDLE. The next burst may start the following cycle.
- busy = (state != IDLE) | cmd FIFO non-empty | data FIFO non-empty.
- err clears only on RST.
- Beat counter is 9 bits; FIFO counts are (DEPTH_LOG2+1) bits; no wrap-around is allowed in either.

Optional Feature:
- Macro: DRAM_WRITE_CTRL_STATS_EN.
- With the macro defined:
  - Adds output burst_count[31:0]: increments on each bvalid&bready.
  - Adds output word_count[31:0]: increments on each W handshake.
  - Both reset to 0 and wrap modulo 2^32.
- Without it: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Single burst: push ctrl {8'd64, 32'h0100_0000} and 64 data words 0..63 with strb F, awready/wready/bready always 1 -> one AW with awaddr 0x0100_0000, awlen 63; 64 W beats with data 0..63; wlast only on beat 63; busy drops 1 cycle after the B handshake.
- Data lag: push ctrl len 16, then 15 words, wait 20 cycles -> awvalid stays 0. Push the 16th word -> awvalid rises; W beats are contiguous under wready=1.
- Backpressure: random awready/wready at 30% duty on 3 back-to-back len-64 bursts -> 192 beats in order, no wvalid gap within a burst, wdata/awaddr stable while stalled.
- Len 0 and bad response: ctrl {8'd0, 32'h0000_1003} plus 256 words -> awaddr 0x0000_1000, awlen 255; return bresp 2'b10 -> err = 1 and stays 1 until RST.
- Overflow: push 17 commands with no AXI ready -> ctrl_full after 16; the 17th is dropped; err = 1. After release, exactly 16 AW handshakes occur.
- Reset mid-burst: assert RST during beat 10 of a len-64 burst -> next cycle wvalid = awvalid = bready = busy = err = 0 and the FIFOs are empty. A fresh len-4 burst then completes normally.
